draw_sequencer: RTL and testbench

- Initiator side of the rectangle-drawer interface.
- Accepts draw commands (press/garbage, draw/erase, position 0-3) from game logic over a valid/ready port and buffers them in a small FIFO.
- Issues commands to the drawer one at a time with a start/done handshake, holding command fields stable until the drawer reports completion.
- A watchdog recovers if the drawer never answers; sits between game FSM and drawer/VGA path.

---
 rtl/draw_sequencer.sv | 153 +++++++++++++++
 tb/tb_draw_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/draw_sequencer.sv
// Initiator side of the rectangle-drawer link: queues game draw commands in a
// small FIFO and issues them one at a time with a start/done handshake plus watchdog.
module draw_sequencer #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_item,
   input  logic       cmd_erase,
   input  logic [1:0] cmd_position,
   output logic       draw_start,
   output logic       draw_item,
   output logic       draw_erase,
   output logic [1:0] draw_position,
   input  logic       draw_done,
   output logic       busy,
   output logic       timeout_err,
   output logic [7:0] done_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = $clog2(TIMEOUT_CYCLES);

   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   // Entry layout: {item, erase, position[1:0]}
   logic [3:0]    mem_q [FIFO_DEPTH];
   logic [3:0]    mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    state_q, state_d;
   logic          draw_start_q, draw_start_d;
   logic          draw_item_q, draw_item_d;
   logic          draw_erase_q, draw_erase_d;
   logic [1:0]    draw_position_q, draw_position_d;
   logic          timeout_err_q, timeout_err_d;
   logic [7:0]    done_count_q, done_count_d;
   logic [WW-1:0] watchdog_q, watchdog_d;
   logic          push;
   logic          pop;

   assign cmd_ready     = reset_n && (count_q < DEPTH_C);
   assign busy          = (state_q != S_IDLE) || (count_q != '0);
   assign draw_start    = draw_start_q;
   assign draw_item     = draw_item_q;
   assign draw_erase    = draw_erase_q;
   assign draw_position = draw_position_q;
   assign timeout_err   = timeout_err_q;
   assign done_count    = done_count_q;

   always_comb begin
      push            = cmd_valid && cmd_ready;
      pop             = (state_q == S_IDLE) && (count_q != '0);
      mem_d           = mem_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      count_d         = count_q;
      state_d         = state_q;
      draw_start_d    = 1'b0;
      draw_item_d     = draw_item_q;
      draw_erase_d    = draw_erase_q;
      draw_position_d = draw_position_q;
      timeout_err_d   = timeout_err_q;
      done_count_d    = done_count_q;
      watchdog_d      = watchdog_q;

      if (push) begin
         mem_d[wr_ptr_q] = {cmd_item, cmd_erase, cmd_position};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      // Push into an empty FIFO is never bypassed: the pop sees it next cycle.
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (pop) begin
               {draw_item_d, draw_erase_d, draw_position_d} = mem_q[rd_ptr_q];
               draw_start_d = 1'b1;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            watchdog_d = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (draw_done) begin
               done_count_d = done_count_q + 8'd1;
               state_d      = S_GAP;
            end else if (watchdog_q == WD_LAST) begin
               timeout_err_d = 1'b1;
               state_d       = S_GAP;
            end else begin
               watchdog_d = watchdog_q + WW'(1);
            end
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         state_q         <= S_IDLE;
         draw_start_q    <= 1'b0;
         draw_item_q     <= 1'b0;
         draw_erase_q    <= 1'b0;
         draw_position_q <= 2'd0;
         timeout_err_q   <= 1'b0;
         done_count_q    <= 8'd0;
         watchdog_q      <= '0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         state_q         <= state_d;
         draw_start_q    <= draw_start_d;
         draw_item_q     <= draw_item_d;
         draw_erase_q    <= draw_erase_d;
         draw_position_q <= draw_position_d;
         timeout_err_q   <= timeout_err_d;
         done_count_q    <= done_count_d;
         watchdog_q      <= watchdog_d;
      end
   end

   // Storage needs no reset; the flushed pointers make stale entries unreachable.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: one task per scenario, inline checks,
// expected values worked out by hand from the sequencer's handshake rules.
module tb_draw_sequencer;

   localparam int T = 4096;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_item;
   logic       cmd_erase;
   logic [1:0] cmd_position;
   logic       draw_start;
   logic       draw_item;
   logic       draw_erase;
   logic [1:0] draw_position;
   logic       draw_done;
   logic       busy;
   logic       timeout_err;
   logic [7:0] done_count;

   int         checks   = 0;
   int         failures = 0;
   logic [3:0] issued[$];
   int         served;

   draw_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_item(cmd_item), .cmd_erase(cmd_erase), .cmd_position(cmd_position),
      .draw_start(draw_start), .draw_item(draw_item), .draw_erase(draw_erase),
      .draw_position(draw_position), .draw_done(draw_done), .busy(busy),
      .timeout_err(timeout_err), .done_count(done_count)
   );

   always #5 clk = ~clk;

   // One clock; records the fields of every start pulse seen.
   task automatic step();
      @(negedge clk);
      if (draw_start === 1'b1) issued.push_back({draw_item, draw_erase, draw_position});
   endtask

   task automatic set_cmd(input logic it, input logic er, input logic [1:0] p);
      cmd_valid = 1'b1; cmd_item = it; cmd_erase = er; cmd_position = p;
   endtask

   // Waits for the next command to be issued, then answers done after lat cycles.
   task automatic serve_next(input int lat);
      int bound = 0;
      while (issued.size() <= served && bound < 50) begin step(); bound++; end
      checks++;
      if (issued.size() <= served) begin
         failures++;
         $display("FAIL serve_wait: issued=%0d required>%0d", issued.size(), served);
      end else begin
         repeat (lat) step();
         draw_done = 1'b1; step(); draw_done = 1'b0;
      end
      served++;
   endtask

   task automatic test_reset();
      repeat (3) step();
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (draw_start !== 1'b0) begin failures++; $display("FAIL rst_start: got %b want 0", draw_start); end
      checks++; if ({draw_item, draw_erase, draw_position} !== 4'b0000) begin failures++;
         $display("FAIL rst_fields: got %b want 0000", {draw_item, draw_erase, draw_position}); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout: got %b want 0", timeout_err); end
      checks++; if (done_count !== 8'd0) begin failures++; $display("FAIL rst_done_count: got %0d want 0", done_count); end
      reset_n = 1'b1;
      repeat (2) step();
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after: got %b want 1", cmd_ready); end
   endtask

   task automatic test_single();
      int hold_bad = 0;
      issued.delete(); served = 0;
      set_cmd(1'b1, 1'b0, 2'd2); step(); cmd_valid = 1'b0;
      checks++; if (draw_start !== 1'b0) begin failures++; $display("FAIL single_early_start: got %b want 0", draw_start); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_queued: got %b want 1", busy); end
      step();
      checks++; if (draw_start !== 1'b1) begin failures++; $display("FAIL single_start: got %b want 1", draw_start); end
      checks++; if ({draw_item, draw_erase, draw_position} !== 4'b1010) begin failures++;
         $display("FAIL single_fields: got %b want 1010", {draw_item, draw_erase, draw_position}); end
      step();
      checks++; if (draw_start !== 1'b0) begin failures++; $display("FAIL single_pulse_width: got %b want 0", draw_start); end
      repeat (2397) begin
         step();
         if (draw_start !== 1'b0 || {draw_item, draw_erase, draw_position} !== 4'b1010) hold_bad++;
      end
      draw_done = 1'b1; step(); draw_done = 1'b0;
      checks++; if (hold_bad !== 0) begin failures++; $display("FAIL single_hold: got %0d bad cycles want 0", hold_bad); end
      checks++; if (done_count !== 8'd1) begin failures++; $display("FAIL single_done_count: got %0d want 1", done_count); end
      checks++; if ({draw_item, draw_erase, draw_position} !== 4'b1010) begin failures++;
         $display("FAIL single_gap_fields: got %b want 1010", {draw_item, draw_erase, draw_position}); end
      step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end: got %b want 0", busy); end
      checks++; if (issued.size() !== 1) begin failures++; $display("FAIL single_pulses: got %0d want 1", issued.size()); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_q [6] = '{4'b1000, 4'b0001, 4'b1010, 4'b0011, 4'b1000, 4'b1111};
      issued.delete(); served = 0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d: got %b want 1", i, cmd_ready); end
         set_cmd((i % 2) == 0, 1'b0, 2'(i % 4)); step();
      end
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_full: got %b want 0", cmd_ready); end
      // Sixth command waits on the full FIFO while the head is popped.
      set_cmd(1'b1, 1'b1, 2'd3); step();
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_full: got %b want 0", cmd_ready); end
      draw_done = 1'b1; step(); draw_done = 1'b0;
      checks++; if (done_count !== 8'd2) begin failures++; $display("FAIL b2b_first_done: got %0d want 2", done_count); end
      step();
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_gap_full: got %b want 0", cmd_ready); end
      step();
      checks++; if (cmd_ready !== 1'b1 || draw_start !== 1'b1 || draw_position !== 2'd1) begin failures++;
         $display("FAIL b2b_pop_edge: got ready=%b start=%b pos=%0d want 1 1 1", cmd_ready, draw_start, draw_position); end
      step(); cmd_valid = 1'b0;
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_refill: got %b want 0", cmd_ready); end
      served = 1;
      repeat (5) serve_next(2);
      repeat (2) step();
      checks++; if (done_count !== 8'd7) begin failures++; $display("FAIL b2b_done_count: got %0d want 7", done_count); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
      checks++; if (issued.size() !== 6) begin failures++; $display("FAIL b2b_issue_count: got %0d want 6", issued.size()); end
      for (int i = 0; i < 6 && i < issued.size(); i++) begin
         checks++; if (issued[i] !== exp_q[i]) begin failures++;
            $display("FAIL b2b_order_%0d: got %b want %b", i, issued[i], exp_q[i]); end
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      issued.delete(); served = 0;
      set_cmd(1'b0, 1'b1, 2'd1); step();
      set_cmd(1'b1, 1'b0, 2'd3); step(); cmd_valid = 1'b0;
      checks++; if (draw_start !== 1'b1) begin failures++; $display("FAIL to_start: got %b want 1", draw_start); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_early: got %b want 0", timeout_err); end
      // ISSUE cycle plus TIMEOUT_CYCLES WAIT cycles before the flag appears.
      while (timeout_err !== 1'b1 && n < T + 20) begin step(); n++; end
      checks++; if (n !== T + 1) begin failures++; $display("FAIL to_latency: got %0d cycles want %0d", n, T + 1); end
      checks++; if (done_count !== 8'd7) begin failures++; $display("FAIL to_done_count: got %0d want 7", done_count); end
      served = 1;
      serve_next(3);
      step();
      checks++; if (issued.size() !== 2 || issued[1] !== 4'b1011) begin failures++;
         $display("FAIL to_next_issue: got n=%0d last=%b want 2 1011", issued.size(), issued[issued.size()-1]); end
      checks++; if (done_count !== 8'd8) begin failures++; $display("FAIL to_next_done: got %0d want 8", done_count); end
      checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
   endtask

   task automatic test_reset_mid_wait();
      set_cmd(1'b1, 1'b1, 2'd0); step();
      set_cmd(1'b0, 1'b1, 2'd1); step();
      set_cmd(1'b1, 1'b0, 2'd2); step(); cmd_valid = 1'b0;
      repeat (3) step();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmw_busy_before: got %b want 1", busy); end
      reset_n = 1'b0; step();
      checks++; if (busy !== 1'b0 || draw_start !== 1'b0) begin failures++;
         $display("FAIL rmw_state: got busy=%b start=%b want 0 0", busy, draw_start); end
      checks++; if ({draw_item, draw_erase, draw_position} !== 4'b0000) begin failures++;
         $display("FAIL rmw_fields: got %b want 0000", {draw_item, draw_erase, draw_position}); end
      checks++; if (done_count !== 8'd0 || timeout_err !== 1'b0) begin failures++;
         $display("FAIL rmw_counters: got done=%0d to=%b want 0 0", done_count, timeout_err); end
      reset_n = 1'b1; draw_done = 1'b1; step(); draw_done = 1'b0;
      checks++; if (done_count !== 8'd0) begin failures++; $display("FAIL rmw_late_done: got %0d want 0", done_count); end
      repeat (3) step();
      checks++; if (busy !== 1'b0 || draw_start !== 1'b0 || cmd_ready !== 1'b1) begin failures++;
         $display("FAIL rmw_flushed: got busy=%b start=%b ready=%b want 0 0 1", busy, draw_start, cmd_ready); end
   endtask

   task automatic test_spurious_done();
      draw_done = 1'b1; repeat (3) step(); draw_done = 1'b0;
      checks++; if (done_count !== 8'd0 || busy !== 1'b0 || draw_start !== 1'b0) begin failures++;
         $display("FAIL sp_idle: got done=%0d busy=%b start=%b want 0 0 0", done_count, busy, draw_start); end
      set_cmd(1'b1, 1'b0, 2'd1); step(); cmd_valid = 1'b0; step();
      checks++; if (draw_start !== 1'b1) begin failures++; $display("FAIL sp_issue_start: got %b want 1", draw_start); end
      draw_done = 1'b1; step(); draw_done = 1'b0;
      checks++; if (done_count !== 8'd0) begin failures++; $display("FAIL sp_issue_done: got %0d want 0", done_count); end
      repeat (3) step();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sp_still_wait: got %b want 1", busy); end
      draw_done = 1'b1; step(); draw_done = 1'b0;
      checks++; if (done_count !== 8'd1) begin failures++; $display("FAIL sp_real_done: got %0d want 1", done_count); end
      repeat (2) step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sp_busy_end: got %b want 0", busy); end
   endtask

   initial begin
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_item = 1'b0; cmd_erase = 1'b0;
      cmd_position = 2'd0; draw_done = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_timeout();
      test_reset_mid_wait();
      test_spurious_done();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded 500000 ns");
      $fatal(1);
   end

endmodule
